// File: rtl/dcache_pkg.sv
// Shared types, default geometry and line helpers for the 2-way data cache.
// Optional feature macro used by the top: DCACHE_PERF_CNT_EN.
package dcache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_SETS   = 16;
    localparam int DEF_WORD_W = 32;

    localparam int OFF_W  = $clog2(DEF_LINE_W / 8);
    localparam int IDX_W  = $clog2(DEF_SETS);
    localparam int TAG_W  = DEF_ADDR_W - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;

    // Upper bounds for the generic word-insert helper; instances must stay within them.
    localparam int MAX_LINE_W = 1024;
    localparam int MAX_WORD_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_REFILL,
        S_REFILL_DONE
    } state_t;

    function automatic logic [MAX_LINE_W-1:0] line_word_insert(
        input logic [MAX_LINE_W-1:0] line,
        input int                    wsel,
        input logic [MAX_WORD_W-1:0] word,
        input int                    word_w
    );
        logic [MAX_LINE_W-1:0] mask;
        logic [MAX_LINE_W-1:0] ins;
        mask = '0;
        for (int b = 0; b < MAX_WORD_W; b++) begin
            if (b < word_w) mask[b] = 1'b1;
        end
        ins = '0;
        ins[MAX_WORD_W-1:0] = word;
        mask = mask << (wsel * word_w);
        ins  = (ins << (wsel * word_w)) & mask;
        return (line & ~mask) | ins;
    endfunction

endpackage

// File: rtl/dcache_2way_way_store.sv
// Storage for one cache way: valid/dirty/tag/data per set.
// Synchronous write port, combinational read by index; reset clears valid and dirty only.
module dcache_way_store
    import dcache_pkg::*;
#(
    parameter int SETS     = DEF_SETS,
    parameter int TAG_BITS = TAG_W,
    parameter int LINE_W   = DEF_LINE_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [$clog2(SETS)-1:0] rd_idx,
    output logic                    rd_valid,
    output logic                    rd_dirty,
    output logic [TAG_BITS-1:0]     rd_tag,
    output logic [LINE_W-1:0]       rd_data,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_idx,
    input  logic                    wr_valid,
    input  logic                    wr_dirty,
    input  logic [TAG_BITS-1:0]     wr_tag,
    input  logic [LINE_W-1:0]       wr_data
);

    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [LINE_W-1:0]   data_q [SETS];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with per-set 1-bit LRU.
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int SETS   = DEF_SETS,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output state_t            dbg_state
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit_o,
    output logic [31:0]       perf_miss_o,
    output logic [31:0]       perf_wb_o
`endif
);

    // Package widths describe the default build; these follow the instance parameters.
    localparam int OFF_BITS  = $clog2(LINE_W / 8);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_W - OFF_BITS - IDX_BITS;
    localparam int WSEL_BITS = OFF_BITS - 2;

    logic                 req;
    logic                 is_write;
    logic [TAG_BITS-1:0]  req_tag;
    logic [IDX_BITS-1:0]  req_idx;
    logic [WSEL_BITS-1:0] req_wsel;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_write = p1_MemWrite_i;
    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_BITS];
    assign req_idx  = p1_addr_i[OFF_BITS +: IDX_BITS];
    assign req_wsel = p1_addr_i[OFF_BITS-1:2];

    state_t state_q, state_d;
    logic   victim_q, victim_d;
    logic   mem_enable_q, mem_enable_d;
    logic   mem_write_q, mem_write_d;
    logic [SETS-1:0] lru_q;

    logic [1:0]          way_valid;
    logic [1:0]          way_dirty;
    logic [TAG_BITS-1:0] way_tag  [2];
    logic [LINE_W-1:0]   way_data [2];

    logic [1:0]          wr_en;
    logic                wr_dirty;
    logic [LINE_W-1:0]   wr_data;

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way_store #(
            .SETS     (SETS),
            .TAG_BITS (TAG_BITS),
            .LINE_W   (LINE_W)
        ) u_store (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rd_idx   (req_idx),
            .rd_valid (way_valid[w]),
            .rd_dirty (way_dirty[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w]),
            .wr_en    (wr_en[w]),
            .wr_idx   (req_idx),
            .wr_valid (1'b1),
            .wr_dirty (wr_dirty),
            .wr_tag   (req_tag),
            .wr_data  (wr_data)
        );
    end

    // Hit detection; way 0 wins if both ways claim the tag.
    logic                hit0, hit1, hit, hit_way;
    logic [LINE_W-1:0]   hit_line;
    logic [WORD_W-1:0]   hit_word;

    assign hit0     = way_valid[0] && (way_tag[0] == req_tag);
    assign hit1     = way_valid[1] && (way_tag[1] == req_tag);
    assign hit      = req && (hit0 || hit1);
    assign hit_way  = !hit0;
    assign hit_line = hit_way ? way_data[1] : way_data[0];
    assign hit_word = hit_line[32'(req_wsel) * WORD_W +: WORD_W];

    assign p1_data_o  = hit ? hit_word : '0;
    assign p1_stall_o = (req && !hit) || (state_q != S_IDLE);
    assign dbg_state  = state_q;

    logic [MAX_LINE_W-1:0] merged_full;
    assign merged_full = line_word_insert(MAX_LINE_W'(hit_line), 32'(req_wsel),
                                          MAX_WORD_W'(p1_data_i), WORD_W);

    // Victim choice: first invalid way (way 0 first), else the LRU way.
    logic                victim_sel;
    logic [TAG_BITS-1:0] vic_tag;
    logic [LINE_W-1:0]   vic_line;

    assign victim_sel = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : lru_q[req_idx];
    assign vic_tag    = victim_q ? way_tag[1]  : way_tag[0];
    assign vic_line   = victim_q ? way_data[1] : way_data[0];

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) state_d = S_MISS;
            end
            S_MISS: begin
                victim_d     = victim_sel;
                mem_enable_d = 1'b1;
                if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
                    state_d     = S_WRITEBACK;
                    mem_write_d = 1'b1;
                end else begin
                    state_d     = S_REFILL;
                    mem_write_d = 1'b0;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = S_REFILL;
                    mem_write_d = 1'b0;
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d      = S_REFILL_DONE;
                    mem_enable_d = 1'b0;
                end
            end
            S_REFILL_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // One write port per way: refill installs a clean line, a store hit merges a word.
    always_comb begin
        wr_en    = '0;
        wr_dirty = 1'b0;
        wr_data  = mem_data_i;
        if (state_q == S_REFILL && mem_ack_i) begin
            wr_en[victim_q] = 1'b1;
        end else if (state_q == S_IDLE && hit && is_write) begin
            wr_en[hit_way] = 1'b1;
            wr_dirty       = 1'b1;
            wr_data        = merged_full[LINE_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lru_q <= '0;
        end else if (state_q == S_IDLE && hit) begin
            lru_q[req_idx] <= ~hit_way;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = !mem_enable_q ? '0 :
                          mem_write_q   ? {vic_tag, req_idx, {OFF_BITS{1'b0}}} :
                                          {req_tag, req_idx, {OFF_BITS{1'b0}}};
    assign mem_data_o   = (mem_enable_q && mem_write_q) ? vic_line : '0;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && hit && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == S_IDLE && req && !hit && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == S_MISS && state_d == S_WRITEBACK && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign perf_hit_o  = hit_cnt_q;
    assign perf_miss_o = miss_cnt_q;
    assign perf_wb_o   = wb_cnt_q;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, p1_addr_i[1:0], merged_full[MAX_LINE_W-1:LINE_W]};

endmodule

// File: tb/tb_dcache_2way.sv
// Randomised bench for dcache_2way against a set/way/LRU reference model and a line memory.
`timescale 1ns/1ps
module tb_dcache_2way;
    import dcache_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int NS = 16;
    localparam int WW = 32;
    localparam int NWORDS = LW / WW;
    localparam int LINE_BYTES = LW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [LW-1:0] mem_data_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [LW-1:0] mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_enable_o;
    logic          mem_write_o;
    logic [WW-1:0] p1_data_i = '0;
    logic [AW-1:0] p1_addr_i = '0;
    logic          p1_MemRead_i = 1'b0;
    logic          p1_MemWrite_i = 1'b0;
    logic [WW-1:0] p1_data_o;
    logic          p1_stall_o;
    state_t        dbg_state;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]   perf_hit_o, perf_miss_o, perf_wb_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_2way #(.ADDR_W(AW), .LINE_W(LW), .SETS(NS), .WORD_W(WW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .p1_data_i     (p1_data_i),
        .p1_addr_i     (p1_addr_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .dbg_state     (dbg_state)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .perf_hit_o    (perf_hit_o),
        .perf_miss_o   (perf_miss_o),
        .perf_wb_o     (perf_wb_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit abort    = 1'b0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Backing memory: lines not yet written hold an address-derived pattern.
    logic [LW-1:0] mem [int unsigned];

    function automatic logic [LW-1:0] mem_line(input int unsigned a);
        logic [LW-1:0] l;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < NWORDS; w++) l[w*WW +: WW] = a ^ (32'h9E37_0000 + w * 32'h0101_0101);
        return l;
    endfunction

    function automatic logic [WW-1:0] get_word(input logic [LW-1:0] l, input int w);
        return l[w*WW +: WW];
    endfunction

    // Reference model: per set, two entries and the way to evict next.
    bit            m_valid [NS][2];
    bit            m_dirty [NS][2];
    int unsigned   m_tag   [NS][2];
    logic [LW-1:0] m_line  [NS][2];
    int            m_lru   [NS];
    int            m_hits, m_misses, m_wbs;

    logic [WW-1:0] last_rdata;
    logic [AW-1:0] last_wb_addr;
    logic [LW-1:0] last_wb_line;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_lru[s] = 0;
        end
        m_hits = 0;
        m_misses = 0;
        m_wbs = 0;
    endtask

    // Acts as memory for one transaction: wait for the request, check it, ack after a random delay.
    task automatic serve(input bit wr, input int unsigned addr, input logic [LW-1:0] wdata,
                         input logic [LW-1:0] rdata);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!mem_enable_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("mem_req_seen", mem_enable_o, 1'b1);
        if (!mem_enable_o) begin
            abort = 1'b1;
            return;
        end
        check(wr ? "wb_write" : "rf_write", mem_write_o, wr);
        check(wr ? "wb_addr" : "rf_addr", mem_addr_o, addr);
        if (wr) begin
            check("wb_data", mem_data_o, wdata);
            last_wb_addr = mem_addr_o;
            last_wb_line = mem_data_o;
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk_i);
            check("mem_hold", mem_enable_o, 1'b1);
        end
        mem_data_i = rdata;
        mem_ack_i  = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = {8{$urandom()}};
    endtask

    // One CPU access held until accepted; model predicts hit/miss, victim and memory traffic.
    task automatic access(input bit rd, input bit wr, input int unsigned a, input logic [WW-1:0] d);
        int unsigned idx, tg, wd, way, vic, line_a;
        bit is_hit;
        idx = (a / LINE_BYTES) % NS;
        tg  = a / (LINE_BYTES * NS);
        wd  = (a % LINE_BYTES) / 4;
        line_a = a - (a % LINE_BYTES);
        is_hit = 1'b0;
        way = 0;
        if (m_valid[idx][0] && m_tag[idx][0] == tg) begin is_hit = 1'b1; way = 0; end
        else if (m_valid[idx][1] && m_tag[idx][1] == tg) begin is_hit = 1'b1; way = 1; end

        p1_addr_i = a;
        p1_data_i = d;
        p1_MemRead_i = rd;
        p1_MemWrite_i = wr;
        @(negedge clk_i);
        check("stall_first", p1_stall_o, !is_hit);
        check("rdata_first", p1_data_o, is_hit ? get_word(m_line[idx][way], wd) : 32'h0);
        if (is_hit) check("hit_no_mem", mem_enable_o, 1'b0);
        last_rdata = p1_data_o;

        if (!is_hit) begin
            m_misses++;
            vic = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : m_lru[idx]);
            if (m_valid[idx][vic] && m_dirty[idx][vic]) begin
                m_wbs++;
                serve(1'b1, m_tag[idx][vic] * LINE_BYTES * NS + idx * LINE_BYTES,
                      m_line[idx][vic], '0);
                if (abort) return;
                mem[m_tag[idx][vic] * LINE_BYTES * NS + idx * LINE_BYTES] = m_line[idx][vic];
            end
            serve(1'b0, line_a, '0, mem_line(line_a));
            if (abort) return;
            m_valid[idx][vic] = 1'b1;
            m_dirty[idx][vic] = 1'b0;
            m_tag[idx][vic]   = tg;
            m_line[idx][vic]  = mem_line(line_a);
            way = vic;
            @(negedge clk_i);
            check("stall_refill_done", p1_stall_o, 1'b1);
            check("enable_after_ack", mem_enable_o, 1'b0);
            @(negedge clk_i);
            check("stall_released", p1_stall_o, 1'b0);
            check("rdata_after_fill", p1_data_o, get_word(m_line[idx][way], wd));
            last_rdata = p1_data_o;
        end

        m_hits++;
        if (wr) begin
            m_line[idx][way][wd*WW +: WW] = d;
            m_dirty[idx][way] = 1'b1;
        end
        m_lru[idx] = 1 - way;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic idle_cycle(input bit spurious_ack);
        mem_ack_i = spurious_ack;
        @(negedge clk_i);
        check("idle_stall", p1_stall_o, 1'b0);
        check("idle_enable", mem_enable_o, 1'b0);
        check("idle_rdata", p1_data_o, 32'h0);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] l40;
        int n;
        model_reset();
        last_wb_addr = '0;
        last_wb_line = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_addr", mem_addr_o, '0);
        check("rst_mdata", mem_data_o, '0);
        check("rst_stall_noreq", p1_stall_o, 1'b0);
        check("rst_state", dbg_state, S_IDLE);
        p1_addr_i = 32'h40;
        p1_MemRead_i = 1'b1;
        #1;
        check("rst_stall_req", p1_stall_o, 1'b1);
        check("rst_rdata", p1_data_o, 32'h0);
        p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Cold read with a known refill word
        l40 = mem_line(32'h40);
        l40[31:0] = 32'hDEAD_BEEF;
        mem[32'h40] = l40;
        access(1'b1, 1'b0, 32'h40, 32'h0);
        check("t1_word", last_rdata, 32'hDEAD_BEEF);

        // Two tags in set 2, then a hit on the first
        access(1'b1, 1'b0, 32'h240, 32'h0);
        access(1'b1, 1'b0, 32'h40, 32'h0);

        // Dirty LRU victim writeback
        access(1'b0, 1'b1, 32'h44, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h640, 32'h0);
        last_wb_addr = '0;
        access(1'b1, 1'b0, 32'h240, 32'h0);
        check("t3_wb_addr", last_wb_addr, 32'h40);
        check("t3_wb_word1", get_word(last_wb_line, 1), 32'h1234_5678);

        // Write miss then read back
        access(1'b0, 1'b1, 32'h88, 32'hA5A5_A5A5);
        access(1'b1, 1'b0, 32'h88, 32'h0);
        check("t4_word", last_rdata, 32'hA5A5_A5A5);

        // Read and write together on a hit are a store
        access(1'b1, 1'b1, 32'h8C, 32'h0BAD_F00D);
        access(1'b1, 1'b0, 32'h8C, 32'h0);
        check("t6_word", last_rdata, 32'h0BAD_F00D);

        // Reset in the middle of a writeback
        access(1'b0, 1'b1, 32'h60, 32'h1111_0001);
        access(1'b0, 1'b1, 32'h260, 32'h2222_0002);
        p1_addr_i = 32'h460;
        p1_MemRead_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!mem_enable_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("t5_wb_started", mem_write_o, 1'b1);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t5_enable", mem_enable_o, 1'b0);
        check("t5_write", mem_write_o, 1'b0);
        check("t5_addr", mem_addr_o, '0);
        check("t5_stall", p1_stall_o, 1'b1);
        check("t5_rdata", p1_data_o, 32'h0);
        p1_MemRead_i = 1'b0;
        rst_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        access(1'b1, 1'b0, 32'h60, 32'h0);

        // Random traffic over a few sets and tags to force conflicts and evictions
        for (int i = 0; i < 300 && !abort; i++) begin
            int op;
            int unsigned a;
            op = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            access(op != 1, op != 0, a, $urandom());
            if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
        end

`ifdef DCACHE_PERF_CNT_EN
        @(negedge clk_i);
        check("perf_hit", perf_hit_o, m_hits);
        check("perf_miss", perf_miss_o, m_misses);
        check("perf_wb", perf_wb_o, m_wbs);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- Parametrised successor to the direct-mapped write-back data cache: 2-way set-associative, write-back, write-allocate.
- Per-set 1-bit LRU replacement.
- Sits between the CPU MEM stage (p1_* interface) and the line-wide data memory (mem_* interface).
- Line width, set count and address width are parameters; the block stalls the pipeline on a miss and serialises any writeback before refill.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits (power of 2, >=64).
- SETS, 16, number of sets (power of 2, >=2).
- WORD_W, 32, CPU word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- mem_data_i  in  LINE_W  refill line from memory
- mem_ack_i  in  1  single-cycle completion pulse from memory
- mem_data_o  out  LINE_W  victim line on writeback
- mem_addr_o  out  ADDR_W  line-aligned memory address
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=writeback, 0=refill read
- p1_data_i  in  WORD_W  store data
- p1_addr_i  in  ADDR_W  byte address (word-aligned)
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  WORD_W  load data
- p1_stall_o  out  1  stall pipeline

Behaviour:

Address split:
- Offset is the low log2(LINE_W/8) bits. Word select is offset[OFF_W-1:2]; bits [1:0] are ignored.
- Index is the next log2(SETS) bits. Tag is the remaining bits.

Per way, per set storage: valid, dirty, tag, data. Per set: lru, which names the way to evict next.

Requests:
- req = MemRead|MemWrite. If both are asserted, the request is treated as a write.

Hit path:
- Hit is combinational, in the same cycle as the request, when valid && tag match in either way.
- If both ways match (illegal state), way 0 wins.
- p1_data_o is the selected word of the hit way; it is 0 when there is no hit.
- A write hit updates the selected word and sets dirty at the clock edge.
- Any hit sets lru to the other way.

Stall:
- p1_stall_o = req & ~hit, or state != IDLE.

FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- IDLE -> MISS on req & ~hit. In MISS, the victim is chosen:
  - the first invalid way, way 0 preferred;
  - otherwise the lru way.
- The victim is latched in a register and held until return to IDLE.
- MISS -> WRITEBACK if the victim is valid & dirty:
  - mem_enable=1, mem_write=1;
  - mem_addr = {victim tag, index, 0};
  - mem_data_o = victim line.
- MISS -> REFILL otherwise:
  - mem_enable=1, mem_write=0;
  - mem_addr = {req tag, index, 0}.
- WRITEBACK on ack -> REFILL: mem_write drops; mem_enable stays high; the address switches to the refill address.
- REFILL on ack -> REFILL_DONE:
  - mem_enable=0;
  - the victim way is written with mem_data_i, valid=1, dirty=0, tag=req tag.
- REFILL_DONE -> IDLE. The request then hits on the next cycle; stores merge on that hit.
- mem_enable_o and mem_write_o are registered. mem_addr_o and mem_data_o are stable while mem_enable_o is high.
- The CPU holds p1_addr_i, p1_data_i and the request stable while stalled.
- mem_ack_i outside WRITEBACK/REFILL is ignored.

Reset (rst_i=0 at a clock edge), including mid-transaction:
- State -> IDLE; all valid, dirty and lru bits cleared.
- mem_enable_o=0, mem_write_o=0. Any outstanding memory transaction is abandoned.
- mem_addr_o and mem_data_o are 0 when mem_enable_o=0.
- p1_stall_o follows req, since all ways are invalid; p1_data_o=0.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds outputs perf_hit_o, perf_miss_o and perf_wb_o (32 bits each, saturating).
  - perf_hit_o increments once per accepted hit, counted only in IDLE.
  - perf_miss_o increments on the IDLE->MISS transition.
  - perf_wb_o increments on entry to WRITEBACK.
  - All three clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum;
  - localparams OFF_W, IDX_W, TAG_W, WSEL_W derived from the parameters;
  - helper function line_word_insert(line, wsel, word).
- Sub-module dcache_way_store, instantiated twice:
  - valid/dirty/tag/data arrays for one way;
  - synchronous write port, combinational read by index.
- The top level holds the FSM, LRU array and hit/victim muxing.

Test Plan:
1. Cold read of 0x0000_0040 after reset: stall is asserted. Refill request is at 0x40, mem_write=0; ack returns a line with word 0 = 0xDEADBEEF. Stall drops 2 cycles after ack and p1_data_o = 0xDEADBEEF.
2. Two tags mapping to set 2 (SETS=16, LINE_W=256: 0x0040 and 0x0240), then a read of 0x0040: the third access hits with no memory request.
3. Store 0x12345678 to 0x0044 (hit), then read 0x0640: way 1 is LRU and clean, so refill only. Then read 0x0240: the victim is way 0 (dirty). Writeback goes to 0x0040 with word 1 = 0x12345678, followed by a refill of 0x0240.
4. Write miss at 0x0088 with data 0xA5A5A5A5: refill from 0x0080, merge on the hit. A following read of 0x0088 returns 0xA5A5A5A5 and dirty=1.
5. Reset asserted during WRITEBACK, ack not yet seen: mem_enable_o=0 on the next edge. A re-read of the previously cached address misses.
6. Both MemRead and MemWrite asserted at the same address: treated as a store, data is written, no extra stall cycles on a hit. With DCACHE_PERF_CNT_EN defined, the counters match the scenario counts (e.g. test 3 gives wb=1).
